// File: rtl/ctrl_pipeline.sv
// ctrl_pipeline: decodes IF/ID and carries control bundles ID->EX->MEM->WB with load-use, MUL-hold and redirect handling
module ctrl_pipeline #(
    parameter int REG_AW  = 5,
    parameter int EN_MUL  = 1,
    parameter int MUL_LAT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       instr_id,
    input  logic              valid_id,
    input  logic              redirect,
    output logic [11:0]       ex_ctrl,
    output logic [REG_AW-1:0] ex_rd,
    output logic [5:0]        mem_ctrl,
    output logic [REG_AW-1:0] mem_rd,
    output logic [3:0]        wb_ctrl,
    output logic [REG_AW-1:0] wb_rd,
    output logic              stall,
    output logic              flush_ifid,
    output logic              illegal
);
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic       MUL_ON = EN_MUL != 0;
    localparam logic [3:0] MUL_INIT = 4'(MUL_LAT - 1);
    logic [6:0] opc;
    logic is_op, is_op_imm, is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc;
    logic known, is_mul, dec_valid, use_rs1, use_rs2, load_use, mul_busy, ex_take;
    logic [1:0] alu_op, ct, wb_src;
    logic [11:0] dec_ctrl;
    logic [REG_AW-1:0] rs1, rs2, rd;
    logic [3:0] mul_cnt;
    logic unused_funct3;
    assign unused_funct3 = ^instr_id[14:12];
    assign opc       = instr_id[6:0];
    assign is_op     = opc == OP;
    assign is_op_imm = opc == OP_IMM;
    assign is_load   = opc == LOAD;
    assign is_store  = opc == STORE;
    assign is_branch = opc == BRANCH;
    assign is_jal    = opc == JAL;
    assign is_jalr   = opc == JALR;
    assign is_lui    = opc == LUI;
    assign is_auipc  = opc == AUIPC;
    assign known     = is_op | is_op_imm | is_load | is_store | is_branch | is_jal | is_jalr | is_lui | is_auipc;
    assign is_mul    = MUL_ON & is_op & (instr_id[31:25] == 7'b0000001);
    assign rs1       = instr_id[15+:REG_AW];
    assign rs2       = instr_id[20+:REG_AW];
    assign rd        = instr_id[7+:REG_AW];
    always_comb begin
        alu_op   = is_mul ? 2'b11 : (is_op | is_op_imm) ? 2'b01 : is_branch ? 2'b10 : 2'b00;
        ct       = is_branch ? 2'b01 : is_jal ? 2'b10 : is_jalr ? 2'b11 : 2'b00;
        wb_src   = is_load ? 2'b01 : (is_jal | is_jalr) ? 2'b10 : is_lui ? 2'b11 : 2'b00;
        dec_ctrl = {1'b1, is_op_imm | is_load | is_store | is_jalr | is_auipc, alu_op, ct, is_load, is_store,
                    is_op | is_op_imm | is_load | is_jal | is_jalr | is_lui | is_auipc, wb_src, 1'b0};
    end
    assign dec_valid  = valid_id & known;
    assign use_rs1    = known & ~(is_lui | is_auipc | is_jal);
    assign use_rs2    = is_op | is_store | is_branch;
    assign load_use   = dec_valid & ex_ctrl[11] & ex_ctrl[5] & (ex_rd != '0) &
                        ((use_rs1 & (rs1 == ex_rd)) | (use_rs2 & (rs2 == ex_rd)));
    assign mul_busy   = mul_cnt != 4'd0;
    assign stall      = ~redirect & (load_use | mul_busy);
    assign flush_ifid = redirect;
    assign ex_take    = dec_valid & ~redirect & ~load_use;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_ctrl  <= '0;
            ex_rd    <= '0;
            mem_ctrl <= '0;
            mem_rd   <= '0;
            wb_ctrl  <= '0;
            wb_rd    <= '0;
            mul_cnt  <= '0;
            illegal  <= 1'b0;
        end else begin
            illegal <= valid_id & ~known & ~redirect & ~mul_busy;
            wb_ctrl <= {mem_ctrl[5], mem_ctrl[2:0]};
            wb_rd   <= mem_rd;
            if (mul_busy) begin
                mul_cnt  <= mul_cnt - 4'd1;
                mem_ctrl <= '0;
                mem_rd   <= '0;
            end else begin
                mem_ctrl <= {ex_ctrl[11], ex_ctrl[5:1]};
                mem_rd   <= ex_rd;
                ex_ctrl  <= ex_take ? dec_ctrl : '0;
                ex_rd    <= ex_take ? rd : '0;
                mul_cnt  <= (ex_take & is_mul) ? MUL_INIT : 4'd0;
            end
        end
    end
endmodule

// File: tb/tb_ctrl_pipeline.sv
// tb_ctrl_pipeline: directed stimulus with a MEM/WB scoreboard for ctrl_pipeline
module tb_ctrl_pipeline;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_id;
    logic        valid_id;
    logic        redirect;
    logic [11:0] ex_ctrl;
    logic [4:0]  ex_rd, mem_rd, wb_rd;
    logic [5:0]  mem_ctrl;
    logic [3:0]  wb_ctrl;
    logic        stall, flush_ifid, illegal;
    int checks = 0;
    int errors = 0;
    logic [10:0] mq[$];
    logic [8:0]  wq[$];

    localparam logic [31:0] LD5    = {12'd0, 5'd2, 3'b010, 5'd5, 7'b0000011};
    localparam logic [31:0] ADD651 = {7'd0, 5'd1, 5'd5, 3'd0, 5'd6, 7'b0110011};
    localparam logic [31:0] MUL312 = {7'b0000001, 5'd2, 5'd1, 3'd0, 5'd3, 7'b0110011};
    localparam logic [31:0] BEQ12  = {7'd0, 5'd2, 5'd1, 3'd0, 5'd0, 7'b1100011};
    localparam logic [31:0] LUI7   = {20'h12345, 5'd7, 7'b0110111};
    localparam logic [31:0] BAD    = 32'h0000007F;
    localparam logic [31:0] LD0    = {12'd4, 5'd1, 3'b010, 5'd0, 7'b0000011};
    localparam logic [31:0] ADD600 = {7'd0, 5'd0, 5'd0, 3'd0, 5'd6, 7'b0110011};

    ctrl_pipeline dut (
        .clk(clk), .reset(reset), .instr_id(instr_id), .valid_id(valid_id), .redirect(redirect),
        .ex_ctrl(ex_ctrl), .ex_rd(ex_rd), .mem_ctrl(mem_ctrl), .mem_rd(mem_rd),
        .wb_ctrl(wb_ctrl), .wb_rd(wb_rd), .stall(stall), .flush_ifid(flush_ifid), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [31:0] ins, input logic v, input logic r);
        instr_id = ins;
        valid_id = v;
        redirect = r;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_out(input logic [5:0] mc, input logic [3:0] wc, input logic [4:0] rd);
        mq.push_back({mc, rd});
        wq.push_back({wc, rd});
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ex_ctrl"}, 32'(ex_ctrl), 0);
        chk({tag, "_ex_rd"}, 32'(ex_rd), 0);
        chk({tag, "_mem_ctrl"}, 32'(mem_ctrl), 0);
        chk({tag, "_mem_rd"}, 32'(mem_rd), 0);
        chk({tag, "_wb_ctrl"}, 32'(wb_ctrl), 0);
        chk({tag, "_wb_rd"}, 32'(wb_rd), 0);
        chk({tag, "_stall"}, 32'(stall), 0);
        chk({tag, "_illegal"}, 32'(illegal), 0);
    endtask

    always @(negedge clk) begin
        if (mem_ctrl[5]) begin
            if (mq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mem_sb: got %0h expected nothing", {mem_ctrl, mem_rd});
            end else chk("mem_sb", 32'({mem_ctrl, mem_rd}), 32'(mq.pop_front()));
        end
        if (wb_ctrl[3]) begin
            if (wq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wb_sb: got %0h expected nothing", {wb_ctrl, wb_rd});
            end else chk("wb_sb", 32'({wb_ctrl, wb_rd}), 32'(wq.pop_front()));
        end
    end

    initial begin
        reset = 1'b1;
        drive(32'd0, 1'b0, 1'b0);
        chk_all_zero("rst");
        @(negedge clk);
        reset = 1'b0;
        drive(LD5, 1'b1, 1'b0);
        chk("lu_ld_stall", 32'(stall), 0);
        expect_out(6'h35, 4'hD, 5'd5);
        tick();
        drive(ADD651, 1'b1, 1'b0);
        chk("lu_ex_load", 32'(ex_ctrl), 32'hC2A);
        chk("lu_ex_rd", 32'(ex_rd), 5);
        chk("lu_stall", 32'(stall), 1);
        tick();
        drive(ADD651, 1'b1, 1'b0);
        chk("lu_bubble", 32'(ex_ctrl), 0);
        chk("lu_unstall", 32'(stall), 0);
        expect_out(6'h24, 4'hC, 5'd6);
        tick();
        drive(32'd0, 1'b0, 1'b0);
        chk("lu_ex_add", 32'(ex_ctrl), 32'h908);
        chk("lu_ex_add_rd", 32'(ex_rd), 6);
        tick();
        drive(MUL312, 1'b1, 1'b0);
        chk("mul_in_stall", 32'(stall), 0);
        expect_out(6'h24, 4'hC, 5'd3);
        tick();
        drive(32'd0, 1'b0, 1'b0);
        chk("mul_ex", 32'(ex_ctrl), 32'hB08);
        chk("mul_stall1", 32'(stall), 1);
        tick();
        drive(32'd0, 1'b0, 1'b0);
        chk("mul_stall2", 32'(stall), 1);
        chk("mul_mem_bub1", 32'(mem_ctrl), 0);
        tick();
        drive(32'd0, 1'b0, 1'b0);
        chk("mul_stall3", 32'(stall), 0);
        chk("mul_ex_held", 32'(ex_ctrl), 32'hB08);
        chk("mul_mem_bub2", 32'(mem_ctrl), 0);
        tick();
        drive(32'd0, 1'b0, 1'b0);
        chk("mul_mem", 32'(mem_ctrl), 32'h24);
        chk("mul_mem_rd", 32'(mem_rd), 3);
        tick();
        drive(LD5, 1'b1, 1'b0);
        expect_out(6'h35, 4'hD, 5'd5);
        tick();
        drive(ADD651, 1'b1, 1'b1);
        chk("rd_stall", 32'(stall), 0);
        chk("rd_flush", 32'(flush_ifid), 1);
        tick();
        drive(32'd0, 1'b0, 1'b0);
        chk("rd_bubble", 32'(ex_ctrl), 0);
        chk("rd_flush_off", 32'(flush_ifid), 0);
        tick();
        drive(BEQ12, 1'b1, 1'b0);
        expect_out(6'h20, 4'h8, 5'd0);
        tick();
        drive(BAD, 1'b1, 1'b1);
        chk("beq_ex", 32'(ex_ctrl), 32'hA40);
        chk("beq_flush", 32'(flush_ifid), 1);
        chk("beq_stall", 32'(stall), 0);
        tick();
        drive(32'd0, 1'b0, 1'b0);
        chk("killed_illegal", 32'(illegal), 0);
        chk("beq_bubble", 32'(ex_ctrl), 0);
        tick();
        drive(LUI7, 1'b1, 1'b0);
        expect_out(6'h27, 4'hF, 5'd7);
        tick();
        drive(32'd0, 1'b0, 1'b0);
        chk("lui_ex", 32'(ex_ctrl), 32'h80E);
        chk("lui_ex_rd", 32'(ex_rd), 7);
        tick();
        chk("lui_mem", 32'(mem_ctrl), 32'h27);
        tick();
        chk("lui_wb", 32'(wb_ctrl), 32'hF);
        chk("lui_wb_rd", 32'(wb_rd), 7);
        tick();
        drive(BAD, 1'b1, 1'b0);
        chk("bad_stall", 32'(stall), 0);
        tick();
        drive(32'd0, 1'b0, 1'b0);
        chk("illegal_pulse", 32'(illegal), 1);
        chk("bad_bubble", 32'(ex_ctrl), 0);
        tick();
        drive(LD0, 1'b1, 1'b0);
        chk("illegal_done", 32'(illegal), 0);
        expect_out(6'h35, 4'hD, 5'd0);
        tick();
        drive(ADD600, 1'b1, 1'b0);
        chk("x0_no_stall", 32'(stall), 0);
        expect_out(6'h24, 4'hC, 5'd6);
        tick();
        drive(32'd0, 1'b0, 1'b0);
        chk("x0_ex_add", 32'(ex_ctrl), 32'h908);
        repeat (3) tick();
        chk("drain_mem_q", 32'(mq.size()), 0);
        chk("drain_wb_q", 32'(wq.size()), 0);
        drive(MUL312, 1'b1, 1'b0);
        tick();
        drive(32'd0, 1'b0, 1'b0);
        chk("rm_stall", 32'(stall), 1);
        #1 reset = 1'b1;
        #1 chk_all_zero("rm");
        tick();
        #1 reset = 1'b0;
        drive(ADD651, 1'b1, 1'b0);
        chk("rm_post_stall", 32'(stall), 0);
        chk("rm_post_ex", 32'(ex_ctrl), 0);
        expect_out(6'h24, 4'hC, 5'd6);
        tick();
        drive(32'd0, 1'b0, 1'b0);
        chk("rm_post_add", 32'(ex_ctrl), 32'h908);
        repeat (4) tick();
        chk("final_mem_q", 32'(mq.size()), 0);
        chk("final_wb_q", 32'(wq.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
